// File: rtl/led_anim_player.sv
// ----------------------------------------------------------------------------
// led_anim_player
//
// Plays a stored LED animation. Each frame's 7-bit index goes to an external
// combinational pattern ROM. The pattern that comes back is registered onto
// the active-low LED outputs. An internal prescaler sets the frame rate.
// Playback is controlled by start, stop, pause and an optional loop mode.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       1-cycle pulse: (re)start playback from frame 0
//   stop        1-cycle pulse: abort playback and return to idle
//   pause       level: freezes frame index, prescaler and LEDs while busy
//   rom_idx     registered frame index presented to the pattern ROM
//   rom_data    ROM pattern for rom_idx (combinational)
//   led         registered active-low LED pattern (1 = segment off)
//   busy        high while playing or paused
//   frame_tick  1-cycle pulse following each prescaler wrap
//   done        1-cycle pulse when a non-looping play completes
//
// Build option
//   LED_ANIM_PINGPONG_EN  when defined, playback sweeps up to FRAME_LAST and
//                         then back down to 0. Neither endpoint frame is
//                         repeated. When undefined, playback counts up only.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no playback, LEDs off, rom_idx holds its last value
// ST_RUN   | prescaler counting, LEDs track the ROM pattern
// ST_PAUSE | pause was high on the last edge; everything frozen
// ----------------------------------------------------------------------------
module led_anim_player #(
   parameter int TICK_DIV   = 5000000,
   parameter int CNT_W      = 23,
   parameter int FRAME_LAST = 127,
   parameter int LOOP       = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   output logic [6:0] rom_idx,
   input  logic [6:0] rom_data,
   output logic [6:0] led,
   output logic       busy,
   output logic       frame_tick,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [6:0]       IDX_LAST   = 7'(FRAME_LAST);
   localparam logic [6:0]       LED_OFF    = 7'h7F;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] presc_q, presc_d;
   logic [6:0]       idx_q, idx_d;
   logic [6:0]       led_q, led_d;
   logic             tick_q, tick_d;
   logic             done_q, done_d;
   logic             frame_wrap;
`ifdef LED_ANIM_PINGPONG_EN
   logic             dir_down_q, dir_down_d;
`endif

   always_comb frame_wrap = (presc_q == PRESC_LAST);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      idx_d   = idx_q;
      led_d   = led_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
`ifdef LED_ANIM_PINGPONG_EN
      dir_down_d = dir_down_q;
`endif

      case (state_q)
         ST_IDLE: begin
            // a start that coincides with stop is dropped (stop wins)
            if (start && !stop) begin
               state_d = ST_RUN;
               presc_d = '0;
               idx_d   = '0;
`ifdef LED_ANIM_PINGPONG_EN
               dir_down_d = 1'b0;
`endif
            end
         end

         ST_RUN, ST_PAUSE: begin
            if (stop) begin
               state_d = ST_IDLE;
               presc_d = '0;
               led_d   = LED_OFF;
            end else if (start) begin
               // restart goes to RUN even with pause high; the next edge
               // re-enters PAUSE if pause is still asserted
               state_d = ST_RUN;
               presc_d = '0;
               idx_d   = '0;
`ifdef LED_ANIM_PINGPONG_EN
               dir_down_d = 1'b0;
`endif
            end else if (pause) begin
               // freeze on the first edge pause is seen, so pause time
               // never counts towards the frame dwell
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_RUN;
               led_d   = rom_data;
               if (!frame_wrap) begin
                  presc_d = presc_q + CNT_W'(1);
               end else begin
                  presc_d = '0;
                  tick_d  = 1'b1;
`ifdef LED_ANIM_PINGPONG_EN
                  if (!dir_down_q) begin
                     if (idx_q < IDX_LAST) begin
                        idx_d = idx_q + 7'd1;
                     end else begin
                        dir_down_d = 1'b1;
                        idx_d      = (IDX_LAST != 7'd0) ? IDX_LAST - 7'd1 : 7'd0;
                     end
                  end else if (idx_q != 7'd0) begin
                     idx_d = idx_q - 7'd1;
                  end else if (LOOP != 0) begin
                     dir_down_d = 1'b0;
                     idx_d      = (IDX_LAST != 7'd0) ? 7'd1 : 7'd0;
                  end else begin
                     // one full up-down sweep finished; index stays at 0
                     done_d     = 1'b1;
                     state_d    = ST_IDLE;
                     led_d      = LED_OFF;
                     dir_down_d = 1'b0;
                  end
`else
                  if (idx_q < IDX_LAST) begin
                     idx_d = idx_q + 7'd1;
                  end else if (LOOP != 0) begin
                     idx_d = '0;
                  end else begin
                     // one-shot complete; index is left on the last frame
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                     led_d   = LED_OFF;
                  end
`endif
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            presc_d = '0;
            idx_d   = '0;
            led_d   = LED_OFF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         idx_q   <= '0;
         led_q   <= LED_OFF;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         led_q   <= led_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

`ifdef LED_ANIM_PINGPONG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_down_q <= 1'b0;
      end else begin
         dir_down_q <= dir_down_d;
      end
   end
`endif

   assign rom_idx    = idx_q;
   assign led        = led_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_tick = tick_q;
   assign done       = done_q;

endmodule

// File: doc/led_anim_player.md
Name: led_anim_player

Overview:
- Sequencer that plays stored LED animations.
- Generates the 7-bit frame index that drives the combinational pattern ROM (index in, 7-bit active-low pattern out).
- Captures the returned pattern into a registered LED output.
- Paces playback with an internal frame-rate prescaler and supports start/stop/pause/loop control.

Parameters:
TICK_DIV, 5000000, clock cycles per animation frame (>=2)
CNT_W, 23, prescaler counter width; must hold TICK_DIV-1
FRAME_LAST, 127, last valid frame index (0..127)
LOOP, 1, 1 = restart at frame 0 after FRAME_LAST; 0 = play once then stop

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begin playback from frame 0
stop  in  1  single-cycle pulse; abort playback, return to IDLE
pause  in  1  level; while high in RUN, the frame index and prescaler freeze
rom_idx  out  7  frame index to the pattern ROM; registered
rom_data  in  7  pattern from the ROM, combinational response to rom_idx
led  out  7  registered active-low LED pattern; 1 = segment off
busy  out  1  high in RUN or PAUSE
frame_tick  out  1  one-cycle pulse on each frame advance
done  out  1  one-cycle pulse when a non-looping play completes

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, rom_idx=0, prescaler=0, led=7'b1111111 (all off).
  - busy=0, frame_tick=0, done=0.
- States: IDLE, RUN, PAUSE.
  - IDLE -> RUN on start: rom_idx<=0, prescaler<=0.
  - RUN -> PAUSE when pause=1.
  - PAUSE -> RUN when pause=0.
  - RUN/PAUSE -> IDLE on stop.
- Priority: stop > start > pause.
  - start while busy restarts from frame 0: prescaler cleared, state=RUN even if pause is high. PAUSE is re-entered on the next cycle if pause stays high.
  - start and stop in the same cycle -> IDLE.
- Prescaler in RUN:
  - Increments each cycle.
  - At TICK_DIV-1 it wraps to 0, asserts frame_tick for that cycle, and advances the frame.
- Frame advance:
  - rom_idx<FRAME_LAST: rom_idx+1.
  - rom_idx==FRAME_LAST and LOOP=1: rom_idx<=0.
  - rom_idx==FRAME_LAST and LOOP=0: done=1 for one cycle, state<=IDLE, rom_idx held at FRAME_LAST.
  - rom_idx never exceeds FRAME_LAST. Index arithmetic is 7-bit, with no natural overflow reliance.
- PAUSE: prescaler, rom_idx and led hold their values. frame_tick is never asserted.
- led update:
  - In RUN, led<=rom_data every cycle. Pattern latency is 1 cycle after a rom_idx change.
  - In PAUSE, led holds.
  - Entering IDLE (stop, done, or reset) forces led<=7'b1111111 on the next edge.
- Frame dwell: each frame is shown for exactly TICK_DIV cycles of RUN time, excluding paused cycles.
- Mid-operation reset: all outputs return to reset values immediately, asynchronously. No done pulse.
- pause asserted in IDLE has no effect.

Optional Feature:
- Macro: LED_ANIM_PINGPONG_EN.
- Defined: adds a direction register (reset = up).
  - At FRAME_LAST, direction flips to down and the index steps to FRAME_LAST-1.
  - At 0 while down, direction flips to up and the index steps to 1.
  - Neither endpoint frame is shown twice.
  - With LOOP=0, done fires on the advance out of index 0 while direction is down, i.e. after one full up-down sweep; the index stays 0.
  - start resets direction to up.
- Undefined: up-count only, as described in Behaviour.

Test Plan:
1. Reset/idle: rst_n low mid-RUN at rom_idx=37 -> rom_idx=0, led=7'h7F, busy=0 in the same cycle, no done.
2. Basic play (TICK_DIV=4, LOOP=1, FRAME_LAST=127): start pulse -> frame_tick every 4 cycles; rom_idx 0,1,2…; led equals ROM(rom_idx) one cycle after each change; after 127 the index returns to 0.
3. One-shot (LOOP=0, FRAME_LAST=5, TICK_DIV=4): start -> exactly one done pulse 24 cycles after start; state IDLE, rom_idx=5, led=7'h7F.
4. Pause: pause high for 10 cycles at rom_idx=3, prescaler=2 -> rom_idx, led and prescaler frozen, no frame_tick; after release, the next tick occurs 2 cycles later (prescaler 2 -> 3).
5. Control priority: start and stop in the same cycle while RUN -> IDLE; start while RUN at rom_idx=50 -> rom_idx=0, prescaler=0, busy stays 1.
6. LED_ANIM_PINGPONG_EN (FRAME_LAST=3, TICK_DIV=2, LOOP=1): rom_idx sequence is 0,1,2,3,2,1,0,1,…; with LOOP=0, done is pulsed once after reaching 0 on the way down.
